hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the 5-stage core, replacing the fixed two-source forwarding logic.
- Generates per-source E-stage forwarding selects for NUM_SRC read ports and M-stage store-data forwarding.
- Generates load-use stall/bubble and branch-redirect flushes.
- Runs a counter FSM that holds the pipeline while a multi-cycle MDU op occupies E, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 73 +++++++
 tb/tb_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signal bundle of the hazard controller
interface hazard_ctrl_if #(
    parameter int RFIDX_WIDTH = 5,
    parameter int NUM_SRC     = 2,
    parameter int CNT_WIDTH   = 32
);
    logic [NUM_SRC*RFIDX_WIDTH-1:0] rs_d;
    logic [NUM_SRC-1:0]             rs_used_d;
    logic [NUM_SRC*RFIDX_WIDTH-1:0] rs_e;
    logic [RFIDX_WIDTH-1:0]         rd_e;
    logic                           regwrite_e;
    logic                           memtoreg_e;
    logic                           mdu_start_e;
    logic                           redirect_e;
    logic [RFIDX_WIDTH-1:0]         rd_m;
    logic                           regwrite_m;
    logic                           memwrite_m;
    logic [RFIDX_WIDTH-1:0]         rs2_m;
    logic [RFIDX_WIDTH-1:0]         rd_w;
    logic                           regwrite_w;
    logic [2*NUM_SRC-1:0]           fwd_sel_e;
    logic                           fwd_store_m;
    logic                           stall_f;
    logic                           stall_d;
    logic                           stall_e;
    logic                           flush_d;
    logic                           flush_e;
    logic                           mdu_busy;
    logic [CNT_WIDTH-1:0]           stall_cycles;

    modport master (
        output rs_d, rs_used_d, rs_e, rd_e, regwrite_e, memtoreg_e, mdu_start_e, redirect_e,
               rd_m, regwrite_m, memwrite_m, rs2_m, rd_w, regwrite_w,
        input  fwd_sel_e, fwd_store_m, stall_f, stall_d, stall_e, flush_d, flush_e,
               mdu_busy, stall_cycles
    );

    modport slave (
        input  rs_d, rs_used_d, rs_e, rd_e, regwrite_e, memtoreg_e, mdu_start_e, redirect_e,
               rd_m, regwrite_m, memwrite_m, rs2_m, rd_w, regwrite_w,
        output fwd_sel_e, fwd_store_m, stall_f, stall_d, stall_e, flush_d, flush_e,
               mdu_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load-use/redirect/MDU stalls and flushes, stall-cycle counter
module hazard_ctrl #(
    parameter int RFIDX_WIDTH = 5,
    parameter int NUM_SRC     = 2,
    parameter int MDU_LAT     = 4,
    parameter int CNT_WIDTH   = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic       MDU_STALL = MDU_LAT > 1;
    localparam logic       MDU_LONG  = MDU_LAT > 2;
    localparam logic [3:0] CNT_INIT  = 4'(MDU_LAT - 2);

    state_t               state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [NUM_SRC-1:0]   lu_src;
    logic [2*NUM_SRC-1:0] fwd;
    logic                 lu, stall_mdu;
    logic [CNT_WIDTH-1:0] stall_cnt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [RFIDX_WIDTH-1:0] rs;
        logic                   mhit, whit;
        assign rs            = bus.rs_e[i*RFIDX_WIDTH +: RFIDX_WIDTH];
        assign mhit          = bus.regwrite_m && bus.rd_m != '0 && bus.rd_m == rs;
        assign whit          = bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == rs;
        assign fwd[2*i +: 2] = mhit ? 2'b10 : whit ? 2'b01 : 2'b00;
        assign lu_src[i]     = bus.rs_used_d[i] && bus.rs_d[i*RFIDX_WIDTH +: RFIDX_WIDTH] == bus.rd_e;
    end

    assign lu              = bus.memtoreg_e && bus.regwrite_e && bus.rd_e != '0 && |lu_src;
    assign bus.fwd_sel_e   = fwd;
    assign bus.fwd_store_m = bus.memwrite_m && bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == bus.rs2_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // the start cycle itself is the first stall cycle, so BUSY only covers MDU_LAT-2 more
    always_comb begin
        state_n = state == BUSY ? (cnt == 4'd1 ? IDLE : BUSY) : (bus.mdu_start_e && MDU_LONG ? BUSY : IDLE);
        cnt_n   = state == BUSY ? cnt - 4'd1 : (bus.mdu_start_e && MDU_LONG ? CNT_INIT : cnt);
    end

    always_comb begin
        stall_mdu    = state == BUSY || (bus.mdu_start_e && MDU_STALL);
        bus.stall_f  = !reset && (stall_mdu || (!bus.redirect_e && lu));
        bus.stall_d  = !reset && (stall_mdu || (!bus.redirect_e && lu));
        bus.stall_e  = !reset && stall_mdu;
        bus.flush_d  = reset || (!stall_mdu && bus.redirect_e);
        bus.flush_e  = reset || (!stall_mdu && (bus.redirect_e || lu));
        bus.mdu_busy = !reset && state == BUSY;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (bus.stall_f && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of three hazard_ctrl instances (MDU_LAT 4/1/2)
module tb_hazard_ctrl;
    localparam int          W    = 5;
    localparam int          NS   = 2;
    localparam int          CW   = 4;
    localparam logic [11:0] LATS = {4'd2, 4'd1, 4'd4};

    logic            clk = 1'b0;
    logic            reset;
    logic [NS*W-1:0] rs_d, rs_e;
    logic [NS-1:0]   rs_used_d;
    logic [W-1:0]    rd_e, rd_m, rs2_m, rd_w;
    logic            regwrite_e, memtoreg_e, redirect_e, regwrite_m, memwrite_m, regwrite_w;
    logic [2:0]      start;
    logic [5:0]      ctl [3];
    logic [2*NS-1:0] fwd [3];
    logic            fst [3];
    logic [CW-1:0]   scnt [3];
    int              left [3];
    int              mcnt [3];
    int              total = 0;
    int              bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_ctrl_if #(.RFIDX_WIDTH(W), .NUM_SRC(NS), .CNT_WIDTH(CW)) bus ();
        assign bus.rs_d        = rs_d;
        assign bus.rs_used_d   = rs_used_d;
        assign bus.rs_e        = rs_e;
        assign bus.rd_e        = rd_e;
        assign bus.regwrite_e  = regwrite_e;
        assign bus.memtoreg_e  = memtoreg_e;
        assign bus.mdu_start_e = start[g];
        assign bus.redirect_e  = redirect_e;
        assign bus.rd_m        = rd_m;
        assign bus.regwrite_m  = regwrite_m;
        assign bus.memwrite_m  = memwrite_m;
        assign bus.rs2_m       = rs2_m;
        assign bus.rd_w        = rd_w;
        assign bus.regwrite_w  = regwrite_w;
        assign ctl[g]  = {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d, bus.flush_e, bus.mdu_busy};
        assign fwd[g]  = bus.fwd_sel_e;
        assign fst[g]  = bus.fwd_store_m;
        assign scnt[g] = bus.stall_cycles;
        hazard_ctrl #(.RFIDX_WIDTH(W), .NUM_SRC(NS), .MDU_LAT(int'(LATS[4*g +: 4])), .CNT_WIDTH(CW)) dut (
            .clk(clk), .reset(reset), .bus(bus)
        );
    end

    function automatic int m_lat(input int g);
        return int'(LATS[4*g +: 4]);
    endfunction

    function automatic logic [2*NS-1:0] m_fwd();
        logic [2*NS-1:0] r;
        logic [W-1:0]    s;
        r = '0;
        for (int i = 0; i < NS; i++) begin
            s = rs_e[i*W +: W];
            if (regwrite_m && rd_m != 0 && rd_m == s) r[2*i +: 2] = 2'b10;
            else if (regwrite_w && rd_w != 0 && rd_w == s) r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic m_store();
        return memwrite_m && regwrite_w && rd_w != 0 && rd_w == rs2_m;
    endfunction

    function automatic logic m_lu();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NS; i++) hit |= rs_used_d[i] && rs_d[i*W +: W] == rd_e;
        return memtoreg_e && regwrite_e && rd_e != 0 && hit;
    endfunction

    // left = stall cycles still owed by an MDU op after the current one
    function automatic logic [5:0] m_ctl(input int g);
        if (reset) return 6'b000110;
        if (left[g] > 0 || (start[g] && m_lat(g) > 1)) return {5'b11100, left[g] > 0};
        if (redirect_e) return 6'b000110;
        if (m_lu()) return 6'b110010;
        return 6'b000000;
    endfunction

    function automatic logic m_sf(input int g);
        logic [5:0] c;
        c = m_ctl(g);
        return c[5];
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (reset) begin
                left[g] <= 0;
                mcnt[g] <= 0;
            end else begin
                left[g] <= left[g] > 0 ? left[g] - 1 : (start[g] && m_lat(g) > 1) ? m_lat(g) - 2 : 0;
                if (m_sf(g)) mcnt[g] <= mcnt[g] < 15 ? mcnt[g] + 1 : 15;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rs_d = '0; rs_e = '0; rs_used_d = '0; rd_e = '0; rd_m = '0; rs2_m = '0; rd_w = '0;
        {regwrite_e, memtoreg_e, redirect_e, regwrite_m, memwrite_m, regwrite_w} = '0;
        start = '0;
    endtask

    task automatic set_load_use();
        memtoreg_e = 1; regwrite_e = 1; rd_e = 5'd7; rs_d = {5'd7, 5'd0}; rs_used_d = 2'b10;
    endtask

    task automatic test_reset();
        clear(); reset = 1; regwrite_m = 1; rd_m = 5'd3; rs_e = {5'd0, 5'd3}; start = 3'b111;
        @(negedge clk);
        total++; if (ctl[0] !== 6'b000110) begin bad++; $display("FAIL reset_ctl: got %b want 000110", ctl[0]); end
        total++; if (ctl[2] !== 6'b000110) begin bad++; $display("FAIL reset_ctl_lat2: got %b want 000110", ctl[2]); end
        total++; if (fwd[0] !== 4'b0010) begin bad++; $display("FAIL reset_fwd: got %b want 0010", fwd[0]); end
        total++; if (scnt[0] !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", scnt[0]); end
        tick(); reset = 0; clear();
        @(negedge clk);
        total++; if (ctl[0] !== 6'b000000) begin bad++; $display("FAIL post_reset_ctl: got %b want 000000", ctl[0]); end
        tick();
    endtask

    task automatic test_forward();
        clear(); regwrite_m = 1; rd_m = 5'd5; rs_e = {5'd5, 5'd5}; regwrite_w = 1; rd_w = 5'd5;
        @(negedge clk);
        total++; if (fwd[0] !== 4'b1010) begin bad++; $display("FAIL fwd_m_prio: got %b want 1010", fwd[0]); end
        rd_m = 5'd0; #1;
        total++; if (fwd[0] !== 4'b0101) begin bad++; $display("FAIL fwd_m_x0: got %b want 0101", fwd[0]); end
        regwrite_w = 0; #1;
        total++; if (fwd[0] !== 4'b0000) begin bad++; $display("FAIL fwd_none: got %b want 0000", fwd[0]); end
        rs_e = {5'd6, 5'd5}; rd_m = 5'd6; regwrite_w = 1; #1;
        total++; if (fwd[0] !== 4'b1001) begin bad++; $display("FAIL fwd_mixed: got %b want 1001", fwd[0]); end
        tick();
    endtask

    task automatic test_store();
        clear(); memwrite_m = 1; rs2_m = 5'd9; regwrite_w = 1; rd_w = 5'd9;
        @(negedge clk);
        total++; if (fst[0] !== 1'b1) begin bad++; $display("FAIL store_fwd: got %b want 1", fst[0]); end
        rd_w = 5'd0; rs2_m = 5'd0; #1;
        total++; if (fst[0] !== 1'b0) begin bad++; $display("FAIL store_x0: got %b want 0", fst[0]); end
        rd_w = 5'd9; rs2_m = 5'd9; regwrite_w = 0; #1;
        total++; if (fst[0] !== 1'b0) begin bad++; $display("FAIL store_nowr: got %b want 0", fst[0]); end
        tick();
    endtask

    task automatic test_load_use();
        clear(); set_load_use();
        @(negedge clk);
        total++; if (ctl[0] !== 6'b110010) begin bad++; $display("FAIL lu_stall: got %b want 110010", ctl[0]); end
        tick(); clear();
        @(negedge clk);
        total++; if (ctl[0] !== 6'b000000) begin bad++; $display("FAIL lu_bubble: got %b want 000000", ctl[0]); end
        total++; if (scnt[0] !== 4'd1) begin bad++; $display("FAIL lu_count: got %0d want 1", scnt[0]); end
        set_load_use(); rs_used_d = 2'b01; #1;
        total++; if (ctl[0] !== 6'b000000) begin bad++; $display("FAIL lu_unused: got %b want 000000", ctl[0]); end
        tick();
    endtask

    task automatic test_mdu();
        logic [7:0] se_pat, busy_pat;
        int         n [3];
        int         nb;
        clear(); start = 3'b111; se_pat = '0; busy_pat = '0; n = '{0, 0, 0}; nb = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) n[g] += int'(ctl[g][3]);
            se_pat[k] = ctl[0][3]; busy_pat[k] = ctl[0][0]; nb += int'(ctl[1][0]) + int'(ctl[2][0]);
            tick(); start = '0;
        end
        total++; if (se_pat !== 8'b00000111) begin bad++; $display("FAIL mdu4_stall_e: got %b want 00000111", se_pat); end
        total++; if (busy_pat !== 8'b00000110) begin bad++; $display("FAIL mdu4_busy: got %b want 00000110", busy_pat); end
        total++; if (n[1] !== 0) begin bad++; $display("FAIL mdu1_stalls: got %0d want 0", n[1]); end
        total++; if (n[2] !== 1) begin bad++; $display("FAIL mdu2_stalls: got %0d want 1", n[2]); end
        total++; if (nb !== 0) begin bad++; $display("FAIL mdu_short_busy: got %0d want 0", nb); end
    endtask

    task automatic test_redirect();
        clear(); set_load_use(); redirect_e = 1;
        @(negedge clk);
        total++; if (ctl[0] !== 6'b000110) begin bad++; $display("FAIL redir_over_lu: got %b want 000110", ctl[0]); end
        tick(); clear(); start[0] = 1;
        tick(); start = '0; set_load_use(); redirect_e = 1;
        @(negedge clk);
        total++; if (ctl[0] !== 6'b111001) begin bad++; $display("FAIL redir_in_busy: got %b want 111001", ctl[0]); end
        tick(); clear(); tick(); tick();
    endtask

    task automatic test_reset_busy();
        clear(); start[0] = 1;
        tick(); start = '0;
        @(negedge clk);
        total++; if (ctl[0] !== 6'b111001) begin bad++; $display("FAIL rb_busy: got %b want 111001", ctl[0]); end
        reset = 1; #1;
        total++; if (ctl[0] !== 6'b000110) begin bad++; $display("FAIL rb_in_reset: got %b want 000110", ctl[0]); end
        tick(); reset = 0;
        @(negedge clk);
        total++; if (ctl[0] !== 6'b000000) begin bad++; $display("FAIL rb_idle: got %b want 000000", ctl[0]); end
        total++; if (scnt[0] !== 4'd0) begin bad++; $display("FAIL rb_count: got %0d want 0", scnt[0]); end
        tick();
        @(negedge clk);
        total++; if (ctl[0] !== 6'b000000) begin bad++; $display("FAIL rb_still_idle: got %b want 000000", ctl[0]); end
    endtask

    task automatic test_saturation();
        clear(); set_load_use();
        for (int k = 1; k <= 25; k++) begin
            tick();
            @(negedge clk);
            if (k == 10) begin
                total++; if (scnt[0] !== 4'd10) begin bad++; $display("FAIL sat_mid: got %0d want 10", scnt[0]); end
            end
            if (k == 20) begin
                total++; if (scnt[0] !== 4'd15) begin bad++; $display("FAIL sat_top: got %0d want 15", scnt[0]); end
            end
        end
        total++; if (scnt[0] !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", scnt[0]); end
        total++; if (scnt[2] !== 4'd15) begin bad++; $display("FAIL sat_hold_lat2: got %0d want 15", scnt[2]); end
        tick(); clear();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset = $urandom_range(0, 29) == 0;
            rs_d = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rs_e = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rs_used_d = 2'($urandom_range(0, 3));
            rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
            rs2_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
            {regwrite_e, memtoreg_e, regwrite_m, memwrite_m, regwrite_w} = 5'($urandom);
            redirect_e = $urandom_range(0, 3) == 0;
            for (int g = 0; g < 3; g++) start[g] = $urandom_range(0, 3) == 0;
            @(negedge clk);
            total++; if (fwd[0] !== m_fwd()) begin bad++; $display("FAIL rnd_fwd: cyc %0d got %b want %b", k, fwd[0], m_fwd()); end
            total++; if (fst[0] !== m_store()) begin bad++; $display("FAIL rnd_store: cyc %0d got %b want %b", k, fst[0], m_store()); end
            for (int g = 0; g < 3; g++) begin
                total++; if (ctl[g] !== m_ctl(g)) begin bad++; $display("FAIL rnd_ctl%0d: cyc %0d got %b want %b", g, k, ctl[g], m_ctl(g)); end
                total++; if (int'(scnt[g]) !== mcnt[g]) begin bad++; $display("FAIL rnd_cnt%0d: cyc %0d got %0d want %0d", g, k, scnt[g], mcnt[g]); end
            end
            tick();
        end
    endtask

    initial begin
        reset = 1; clear();
        tick(); tick();
        test_reset();
        test_forward();
        test_store();
        test_load_use();
        test_mdu();
        test_redirect();
        test_reset_busy();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
